// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
//   - alu_op_t and the alu_ctrl operation codes
//   - state_t : control FSM states (IDLE / BUSY / DONE)
//   - is_mul_op() : true for the two multiply codes
package alu_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_AND   = 4'b0000;
    localparam alu_op_t ALU_OR    = 4'b0001;
    localparam alu_op_t ALU_ADD   = 4'b0010;
    localparam alu_op_t ALU_SLTU  = 4'b0101;
    localparam alu_op_t ALU_SUB   = 4'b0110;
    localparam alu_op_t ALU_SLT   = 4'b0111;
    localparam alu_op_t ALU_MULTU = 4'b1000;
    localparam alu_op_t ALU_MULT  = 4'b1001;
    localparam alu_op_t ALU_NOR   = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_mul_op(input alu_op_t op);
        return (op == ALU_MULT) || (op == ALU_MULTU);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the EX stage and the ALU.
//   master : EX stage side (drives the request, consumes the result)
//   slave  : ALU side
// Request : in_valid, in_ready, alu_ctrl, a_in, b_in
// Response: out_valid, out_ready, result, hi, zero, ovf, cout, err
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    alu_pkg::alu_op_t     alu_ctrl;
    logic [WIDTH-1:0]     a_in;
    logic [WIDTH-1:0]     b_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     result;
    logic [WIDTH-1:0]     hi;
    logic                 zero;
    logic                 ovf;
    logic                 cout;
    logic                 err;

    modport master (
        output in_valid, alu_ctrl, a_in, b_in, out_ready,
        input  in_ready, out_valid, result, hi, zero, ovf, cout, err
    );

    modport slave (
        input  in_valid, alu_ctrl, a_in, b_in, out_ready,
        output in_ready, out_valid, result, hi, zero, ovf, cout, err
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier core with optional result negation.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   start_i     : load operands and begin (one cycle pulse)
//   mcand_i     : multiplicand magnitude
//   mplier_i    : multiplier magnitude
//   neg_i       : negate the final 2*WIDTH product
//   done_o      : final iteration happens at the coming edge
//   prod_o      : final (possibly negated) product, valid while done_o
module alu_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   mcand_i,
    input  logic [WIDTH-1:0]   mplier_i,
    input  logic               neg_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] prod_o
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q;
    logic               neg_q;

    logic [WIDTH:0]     upper;
    logic [2*WIDTH-1:0] step;

    // Multiplier lives in the low half of the accumulator and shifts out
    // as the partial product shifts in from the top (carry included).
    always_comb begin
        upper = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
              + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        step  = {upper, acc_q[WIDTH-1:1]};

        acc_d = acc_q;
        cnt_d = cnt_q;
        if (start_i) begin
            acc_d = {{WIDTH{1'b0}}, mplier_i};
            cnt_d = CW'(WIDTH);
        end else if (cnt_q != '0) begin
            acc_d = step;
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Result is handed out combinationally on the last step so the
    // controller can register it in the same edge the count hits zero.
    assign done_o = (cnt_q == CW'(1));
    assign prod_o = neg_q ? (~step + 1'b1) : step;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            neg_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            if (start_i) begin
                mcand_q <= mcand_i;
                neg_q   <= neg_i;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// WIDTH-bit EX-stage ALU: single-cycle logic/add/compare ops and
// multi-cycle MULT/MULTU, behind a valid/ready handshake.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : alu_seq_if slave (request operands/op, response result/flags)
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_seq_if.slave  bus
);
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               cout_q, cout_d;
    logic               err_q, err_d;

    alu_op_t            op;
    logic               b_inv;
    logic [WIDTH-1:0]   bx;
    logic [WIDTH:0]     sum;
    logic               s_ovf;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf, alu_cout, alu_err;
    logic               accept, mul_start, mul_signed, mul_done;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] mul_prod;

    assign op     = bus.alu_ctrl;
    assign accept = bus.in_valid && (state_q == IDLE);

    // One adder serves ADD/SUB/SLT/SLTU; bit 2 of the opcode selects
    // B-invert with carry-in 1 (subtract).
    assign b_inv = op[2];
    assign bx    = b_inv ? ~bus.b_in : bus.b_in;
    assign sum   = {1'b0, bus.a_in} + {1'b0, bx} + {{WIDTH{1'b0}}, b_inv};
    assign s_ovf = (bus.a_in[WIDTH-1] == bx[WIDTH-1]) &&
                   (sum[WIDTH-1] != bus.a_in[WIDTH-1]);

    always_comb begin
        alu_res  = '0;
        alu_ovf  = 1'b0;
        alu_cout = 1'b0;
        alu_err  = 1'b0;
        case (op)
            ALU_AND:  alu_res = bus.a_in & bus.b_in;
            ALU_OR:   alu_res = bus.a_in | bus.b_in;
            ALU_NOR:  alu_res = ~(bus.a_in | bus.b_in);
            ALU_ADD, ALU_SUB: begin
                alu_res  = sum[WIDTH-1:0];
                alu_ovf  = s_ovf;
                alu_cout = sum[WIDTH];
            end
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ s_ovf};
            ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, ~sum[WIDTH]};
            default:  alu_err = 1'b1;
        endcase
    end

    // Signed multiply runs on magnitudes; the most-negative value's
    // magnitude still fits in WIDTH unsigned bits.
    assign mul_signed = (op == ALU_MULT);
    assign a_mag = (mul_signed && bus.a_in[WIDTH-1]) ? (~bus.a_in + 1'b1) : bus.a_in;
    assign b_mag = (mul_signed && bus.b_in[WIDTH-1]) ? (~bus.b_in + 1'b1) : bus.b_in;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (mul_start),
        .mcand_i  (a_mag),
        .mplier_i (b_mag),
        .neg_i    (mul_signed && (bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1])),
        .done_o   (mul_done),
        .prod_o   (mul_prod)
    );

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        hi_d      = hi_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        cout_d    = cout_q;
        err_d     = err_q;
        mul_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_mul_op(op)) begin
                        mul_start = 1'b1;
                        state_d   = BUSY;
                    end else begin
                        result_d = alu_res;
                        hi_d     = '0;
                        zero_d   = (alu_res == '0);
                        ovf_d    = alu_ovf;
                        cout_d   = alu_cout;
                        err_d    = alu_err;
                        state_d  = DONE;
                    end
                end
            end
            BUSY: begin
                if (mul_done) begin
                    hi_d     = mul_prod[2*WIDTH-1:WIDTH];
                    result_d = mul_prod[WIDTH-1:0];
                    zero_d   = (mul_prod[WIDTH-1:0] == '0);
                    ovf_d    = 1'b0;
                    cout_d   = 1'b0;
                    err_d    = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cout_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            cout_q   <= cout_d;
            err_q    <= err_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.hi        = hi_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;
    assign bus.cout      = cout_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    alu_seq_if #(.WIDTH(32)) bus ();

    alu_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until accepted; returns one cycle after accept.
    task automatic issue(input alu_op_t c, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout in_ready=%0b required=1", bus.in_ready);
        end
        bus.alu_ctrl = c;
        bus.a_in     = a;
        bus.b_in     = b;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Cycles since accept until out_valid (bounded at 100).
    task automatic wait_valid(output int n);
        n = 1;
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic pop();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_hs out_valid=%0b in_ready=%0b required 0/1", bus.out_valid, bus.in_ready);
        end
        checks++;
        if (bus.result !== 32'h0 || bus.hi !== 32'h0 ||
            {bus.zero, bus.ovf, bus.cout, bus.err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_out result=%h hi=%h zocE=%b required 0/0/0000",
                     bus.result, bus.hi, {bus.zero, bus.ovf, bus.cout, bus.err});
        end
    endtask

    task automatic test_add();
        issue(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL add_latency out_valid=%0b required=1", bus.out_valid);
        end
        checks++;
        if (bus.result !== 32'h8000_0000 || bus.hi !== 32'h0) begin
            errors++;
            $display("FAIL add_result result=%h hi=%h required 80000000/0", bus.result, bus.hi);
        end
        checks++;
        if ({bus.ovf, bus.cout, bus.zero, bus.err} !== 4'b1000) begin
            errors++;
            $display("FAIL add_flags ocze=%b required=1000", {bus.ovf, bus.cout, bus.zero, bus.err});
        end
        pop();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_pop out_valid=%0b in_ready=%0b required 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_sub_slt();
        issue(ALU_SUB, 32'd5, 32'd5);
        checks++;
        if (bus.result !== 32'h0 || {bus.zero, bus.cout, bus.ovf} !== 3'b110) begin
            errors++;
            $display("FAIL sub_eq result=%h zco=%b required 0/110", bus.result, {bus.zero, bus.cout, bus.ovf});
        end
        pop();
        issue(ALU_SLT, 32'hFFFF_FFFF, 32'h1);
        checks++;
        if (bus.result !== 32'h1 || {bus.zero, bus.ovf, bus.cout} !== 3'b000) begin
            errors++;
            $display("FAIL slt result=%h zoc=%b required 1/000", bus.result, {bus.zero, bus.ovf, bus.cout});
        end
        pop();
        issue(ALU_SLTU, 32'hFFFF_FFFF, 32'h1);
        checks++;
        if (bus.result !== 32'h0 || {bus.zero, bus.ovf, bus.cout} !== 3'b100) begin
            errors++;
            $display("FAIL sltu result=%h zoc=%b required 0/100", bus.result, {bus.zero, bus.ovf, bus.cout});
        end
        pop();
        issue(ALU_NOR, 32'h0F0F_0000, 32'h00F0_0F00);
        checks++;
        if (bus.result !== 32'hF000_F0FF) begin
            errors++;
            $display("FAIL nor result=%h required=f000f0ff", bus.result);
        end
        pop();
    endtask

    task automatic test_mult();
        int  n;
        logic busy_ready;
        issue(ALU_MULT, 32'hFFFF_FFFD, 32'd7);
        n = 1;
        busy_ready = 1'b0;
        while (!bus.out_valid && n < 100) begin
            if (bus.in_ready) busy_ready = 1'b1;
            tick();
            n++;
        end
        checks++;
        if (n != 33) begin
            errors++;
            $display("FAIL mult_latency cycles=%0d required=33", n);
        end
        checks++;
        if (busy_ready !== 1'b0) begin
            errors++;
            $display("FAIL mult_busy_ready in_ready_seen=%0b required=0", busy_ready);
        end
        checks++;
        if (bus.hi !== 32'hFFFF_FFFF || bus.result !== 32'hFFFF_FFEB || bus.zero !== 1'b0) begin
            errors++;
            $display("FAIL mult_neg hi=%h lo=%h zero=%0b required ffffffff/ffffffeb/0",
                     bus.hi, bus.result, bus.zero);
        end
        pop();
        issue(ALU_MULT, 32'h8000_0000, 32'h8000_0000);
        wait_valid(n);
        checks++;
        if (bus.hi !== 32'h4000_0000 || bus.result !== 32'h0 || bus.zero !== 1'b1 || n != 33) begin
            errors++;
            $display("FAIL mult_minmin hi=%h lo=%h zero=%0b cyc=%0d required 40000000/0/1/33",
                     bus.hi, bus.result, bus.zero, n);
        end
        pop();
    endtask

    task automatic test_multu_hold();
        int n;
        issue(ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_valid(n);
        checks++;
        if (n != 33 || bus.hi !== 32'hFFFF_FFFE || bus.result !== 32'h0000_0001) begin
            errors++;
            $display("FAIL multu cyc=%0d hi=%h lo=%h required 33/fffffffe/00000001", n, bus.hi, bus.result);
        end
        // A pending request during DONE must not be taken.
        bus.alu_ctrl = ALU_ADD;
        bus.a_in     = 32'h1234_5678;
        bus.b_in     = 32'h1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.hi !== 32'hFFFF_FFFE || bus.result !== 32'h0000_0001) begin
                errors++;
                $display("FAIL multu_hold%0d ov=%0b ir=%0b hi=%h lo=%h required 1/0/fffffffe/00000001",
                         i, bus.out_valid, bus.in_ready, bus.hi, bus.result);
            end
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL multu_handoff out_valid=%0b in_ready=%0b required 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid_mult();
        logic seen;
        issue(ALU_MULT, 32'd3, 32'd5);
        repeat (9) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.result !== 32'h0 ||
            bus.hi !== 32'h0 || {bus.zero, bus.ovf, bus.cout, bus.err} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_busy ov=%0b ir=%0b lo=%h hi=%h zocE=%b required 0/1/0/0/0000",
                     bus.out_valid, bus.in_ready, bus.result, bus.hi,
                     {bus.zero, bus.ovf, bus.cout, bus.err});
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rst_abort out_valid_seen=%0b required=0", seen);
        end
        issue(ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== 32'hF000_F000) begin
            errors++;
            $display("FAIL and_after_rst ov=%0b result=%h required 1/f000f000", bus.out_valid, bus.result);
        end
        pop();
    endtask

    task automatic test_illegal();
        issue(4'b1111, 32'hDEAD_BEEF, 32'h1234_5678);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.err !== 1'b1 || bus.result !== 32'h0 || bus.hi !== 32'h0) begin
            errors++;
            $display("FAIL illegal ov=%0b err=%0b result=%h hi=%h required 1/1/0/0",
                     bus.out_valid, bus.err, bus.result, bus.hi);
        end
        pop();
        issue(ALU_OR, 32'h0000_000F, 32'h0000_00F0);
        checks++;
        if (bus.err !== 1'b0 || bus.result !== 32'h0000_00FF || bus.zero !== 1'b0) begin
            errors++;
            $display("FAIL or_clears_err err=%0b result=%h zero=%0b required 0/000000ff/0",
                     bus.err, bus.result, bus.zero);
        end
        pop();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.alu_ctrl  = ALU_AND;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_add();
        test_sub_slt();
        test_mult();
        test_multu_hold();
        test_reset_mid_mult();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
